// File: rtl/cpu_csr_pkg.sv
// Shared Zicsr definitions: funct3 codes, CSR map, FSM states.
// Also used by the CSR file so both sides agree on the implemented set.
package cpu_csr_pkg;

  localparam logic [2:0] F3_RW  = 3'd1;
  localparam logic [2:0] F3_RS  = 3'd2;
  localparam logic [2:0] F3_RC  = 3'd3;
  localparam logic [2:0] F3_RWI = 3'd5;
  localparam logic [2:0] F3_RSI = 3'd6;
  localparam logic [2:0] F3_RCI = 3'd7;

  localparam logic [11:0] CSR_CYCLE      = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
  localparam logic [11:0] CSR_TIME       = 12'hC01;
  localparam logic [11:0] CSR_TIMEH      = 12'hC81;
  localparam logic [11:0] CSR_INSTRET    = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH   = 12'hC82;
  localparam logic [11:0] CSR_SSTATUS    = 12'h100;
  localparam logic [11:0] CSR_SIE        = 12'h104;
  localparam logic [11:0] CSR_STVEC      = 12'h105;
  localparam logic [11:0] CSR_SCOUNTEREN = 12'h106;
  localparam logic [11:0] CSR_SENVCFG    = 12'h10A;
  localparam logic [11:0] CSR_SSCRATCH   = 12'h140;
  localparam logic [11:0] CSR_SEPC       = 12'h141;
  localparam logic [11:0] CSR_SCAUSE     = 12'h142;
  localparam logic [11:0] CSR_STVAL      = 12'h143;
  localparam logic [11:0] CSR_SIP        = 12'h144;
  localparam logic [11:0] CSR_SATP       = 12'h180;
  localparam logic [11:0] CSR_SCONTEXT   = 12'h5A8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  function automatic logic is_implemented(input logic [11:0] addr);
    case (addr)
      CSR_CYCLE, CSR_CYCLEH, CSR_TIME,
      CSR_TIMEH, CSR_INSTRET, CSR_INSTRETH,
      CSR_SSTATUS, CSR_SIE, CSR_STVEC,
      CSR_SCOUNTEREN, CSR_SENVCFG,
      CSR_SSCRATCH, CSR_SEPC, CSR_SCAUSE,
      CSR_STVAL, CSR_SIP, CSR_SATP,
      CSR_SCONTEXT: is_implemented = 1'b1;
      default:      is_implemented = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_csr_access_if.sv
// Execute-stage request/response plus CSR file port.
// master = execute stage and CSR file side, slave = access FSM.
interface cpu_csr_access_if;
  logic        start;
  logic [2:0]  funct3;
  logic [11:0] csr_num;
  logic [31:0] rs1_val;
  logic [4:0]  rs1_idx;
  logic [4:0]  rd_idx;
  logic        busy;
  logic        done;
  logic [31:0] rd_val;
  logic        rd_wr;
  logic        illegal;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wr;
  logic [31:0] csr_rdata;

  modport master (
    output start, funct3, csr_num, rs1_val,
    output rs1_idx, rd_idx, csr_rdata,
    input  busy, done, rd_val, rd_wr, illegal,
    input  csr_addr, csr_wdata, csr_wr
  );

  modport slave (
    input  start, funct3, csr_num, rs1_val,
    input  rs1_idx, rd_idx, csr_rdata,
    output busy, done, rd_val, rd_wr, illegal,
    output csr_addr, csr_wdata, csr_wr
  );
endinterface

// File: rtl/cpu_csr_alu.sv
// Zicsr modify step: write, set bits, or clear bits.
// Decodes on funct3[1:0] so register and immediate forms share paths.
module cpu_csr_alu
  import cpu_csr_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] old,
  input  logic [31:0] operand,
  output logic [31:0] new_val
);

  logic is_rs;
  logic is_rc;

  assign is_rs = (funct3[1:0] == F3_RS[1:0]);
  assign is_rc = (funct3[1:0] == F3_RC[1:0]);

  always_comb begin
    new_val = operand;
    unique case (1'b1)
      is_rs:   new_val = old | operand;
      is_rc:   new_val = old & ~operand;
      default: new_val = operand;
    endcase
  end

endmodule

// File: rtl/cpu_csr_access.sv
// Zicsr read-modify-write sequencer between execute and CSR file.
// IDLE -> READ -> (WRITE) -> DONE, all outputs registered.
module cpu_csr_access
  import cpu_csr_pkg::*;
(
  input logic            clk,
  input logic            rst,
  cpu_csr_access_if.slave bus
);

  state_t      state;
  logic [2:0]  f3_q;
  logic [11:0] num_q;
  logic [4:0]  rd_q;
  logic [31:0] op_q;
  logic        src0_q;
  logic [31:0] old_q;
  logic [31:0] new_val;
  logic        wr_intent;
  logic        ill;

  cpu_csr_alu u_alu (
    .funct3  (f3_q),
    .old     (bus.csr_rdata),
    .operand (op_q),
    .new_val (new_val)
  );

  // set/clear with x0/uimm=0 is a pure read
  assign wr_intent = (f3_q[1:0] == F3_RW[1:0]) || !src0_q;
  assign ill = (f3_q[1:0] == 2'b00)
            || !is_implemented(num_q)
            || (wr_intent && (num_q[11:10] == 2'b11));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      f3_q          <= '0;
      num_q         <= '0;
      rd_q          <= '0;
      op_q          <= '0;
      src0_q        <= 1'b0;
      old_q         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rd_val    <= '0;
      bus.rd_wr     <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.csr_addr  <= '0;
      bus.csr_wdata <= '0;
      bus.csr_wr    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            f3_q         <= bus.funct3;
            num_q        <= bus.csr_num;
            rd_q         <= bus.rd_idx;
            src0_q       <= (bus.rs1_idx == 5'd0);
            op_q         <= bus.funct3[2]
                          ? {27'd0, bus.rs1_idx}
                          : bus.rs1_val;
            bus.csr_addr <= bus.csr_num;
            bus.busy     <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          old_q <= bus.csr_rdata;
          if (wr_intent && !ill) begin
            bus.csr_wr    <= 1'b1;
            bus.csr_wdata <= new_val;
            state         <= WRITE;
          end else begin
            bus.done    <= 1'b1;
            bus.rd_val  <= ill ? 32'd0 : bus.csr_rdata;
            bus.rd_wr   <= (rd_q != 5'd0) && !ill;
            bus.illegal <= ill;
            state       <= DONE;
          end
        end
        WRITE: begin
          bus.csr_wr  <= 1'b0;
          bus.done    <= 1'b1;
          bus.rd_val  <= old_q;
          bus.rd_wr   <= (rd_q != 5'd0);
          bus.illegal <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          bus.done    <= 1'b0;
          bus.busy    <= 1'b0;
          bus.rd_wr   <= 1'b0;
          bus.illegal <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_csr_access.sv
// Bench for cpu_csr_access: CSR file model with a free-running cycle
// counter, scoreboard of expected transaction results.
module tb_cpu_csr_access;

  typedef struct packed {
    logic [3:0]  wr_cyc;
    logic [11:0] wr_addr;
    logic [31:0] wdata;
    logic [3:0]  done_cyc;
    logic [31:0] rd_val;
    logic        rd_wr;
    logic        ill;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  res_t sb[$];

  cpu_csr_access_if bus ();

  cpu_csr_access dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.csr_wr) mem[bus.csr_addr] <= bus.csr_wdata;
  end

  assign bus.csr_rdata = (bus.csr_addr == 12'hC00) ? cyc
                       : mem[bus.csr_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic preset(input logic [11:0] a, input logic [31:0] d);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // called at a negedge; returns at the negedge where done is seen
  task automatic run_op(input logic [2:0] f3, input logic [11:0] num,
                        input logic [31:0] v, input logic [4:0] idx,
                        input logic [4:0] rd, input bit hold,
                        output res_t r);
    r = '0;
    bus.start = 1'b1;
    bus.funct3 = f3;
    bus.csr_num = num;
    bus.rs1_val = v;
    bus.rs1_idx = idx;
    bus.rd_idx = rd;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.csr_wr) begin
        r.wr_cyc = 4'(k);
        r.wr_addr = bus.csr_addr;
        r.wdata = bus.csr_wdata;
      end
      if (bus.done) begin
        r.done_cyc = 4'(k);
        r.rd_val = bus.rd_val;
        r.rd_wr = bus.rd_wr;
        r.ill = bus.illegal;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [79:0] got;
    @(negedge clk);
    got = {bus.busy, bus.done, bus.rd_wr, bus.illegal, bus.csr_wr,
           bus.rd_val, bus.csr_addr, bus.csr_wdata};
    vectors++;
    if (got !== 80'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", got);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rw();
    res_t r, e;
    preset(12'h140, 32'h1234_5678);
    sb.push_back('{4'd2, 12'h140, 32'hDEAD_BEEF, 4'd3,
                   32'h1234_5678, 1'b1, 1'b0});
    run_op(3'd1, 12'h140, 32'hDEAD_BEEF, 5'd7, 5'd5, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL csrrw_sscratch: got %h want %h", r, e);
    end
    @(negedge clk);
    vectors++;
    if (mem[12'h140] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rw_mem: got %h want deadbeef", mem[12'h140]);
    end
    vectors++;
    if (bus.csr_addr !== 12'h140 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_hold: got %h/%b want 140/0",
               bus.csr_addr, bus.busy);
    end
  endtask

  task automatic test_set();
    res_t r, e;
    preset(12'h100, 32'h0000_0022);
    sb.push_back('{4'd0, 12'h0, 32'h0, 4'd2,
                   32'h0000_0022, 1'b1, 1'b0});
    run_op(3'd2, 12'h100, 32'h0000_FFFF, 5'd0, 5'd3, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL csrrs_x0: got %h want %h", r, e);
    end
    @(negedge clk);
    preset(12'h100, 32'h0000_0010);
    sb.push_back('{4'd2, 12'h100, 32'h0000_0014, 4'd3,
                   32'h0000_0010, 1'b1, 1'b0});
    run_op(3'd6, 12'h100, 32'hFFFF_0000, 5'd4, 5'd1, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL csrrsi: got %h want %h", r, e);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    res_t r, e;
    preset(12'h104, 32'h0000_000F);
    sb.push_back('{4'd2, 12'h104, 32'h0000_000C, 4'd3,
                   32'h0000_000F, 1'b0, 1'b0});
    run_op(3'd7, 12'h104, 32'hFFFF_FFFF, 5'd3, 5'd0, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL csrrci_rd0: got %h want %h", r, e);
    end
    @(negedge clk);
    vectors++;
    if (mem[12'h104] !== 32'h0000_000C) begin
      miscompares++;
      $display("FAIL rci_mem: got %h want 0000000c", mem[12'h104]);
    end
  endtask

  task automatic test_counter();
    res_t r, e;
    sb.push_back('{4'd0, 12'h0, 32'h0, 4'd2, 32'h0, 1'b0, 1'b1});
    run_op(3'd1, 12'hC00, 32'h5, 5'd1, 5'd2, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL csrrw_cycle: got %h want %h", r, e);
    end
    @(negedge clk);
    sb.push_back('{4'd0, 12'h0, 32'h0, 4'd2, cyc + 1, 1'b1, 1'b0});
    run_op(3'd2, 12'hC00, 32'hFF, 5'd0, 5'd4, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL csrrs_cycle: got %h want %h", r, e);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    res_t r, e;
    sb.push_back('{4'd0, 12'h0, 32'h0, 4'd2, 32'h0, 1'b0, 1'b1});
    run_op(3'd4, 12'h140, 32'h1, 5'd1, 5'd9, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL funct3_4: got %h want %h", r, e);
    end
    @(negedge clk);
    sb.push_back('{4'd0, 12'h0, 32'h0, 4'd2, 32'h0, 1'b0, 1'b1});
    run_op(3'd2, 12'h7FF, 32'h1, 5'd0, 5'd9, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL csr_7ff: got %h want %h", r, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    preset(12'h141, 32'h0000_0055);
    bus.start = 1'b1;
    bus.funct3 = 3'd1;
    bus.csr_num = 12'h141;
    bus.rs1_val = 32'h0000_00AA;
    bus.rs1_idx = 5'd1;
    bus.rd_idx = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.csr_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_write_reached: got %b want 1", bus.csr_wr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.csr_wr !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_drop: got wr=%b busy=%b want 0/0",
               bus.csr_wr, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done || bus.csr_wr || bus.busy) seen = 1'b1;
    end
    vectors++;
    if (seen || mem[12'h141] !== 32'h0000_0055) begin
      miscompares++;
      $display("FAIL rst_no_done: got act=%b mem=%h want 0/00000055",
               seen, mem[12'h141]);
    end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    bit seen;
    preset(12'h140, 32'hCAFE_0001);
    sb.push_back('{4'd2, 12'h140, 32'h0000_0011, 4'd3,
                   32'hCAFE_0001, 1'b1, 1'b0});
    run_op(3'd1, 12'h140, 32'h0000_0011, 5'd2, 5'd2, 1'b1, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL held_start_op: got %h want %h", r, e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (bus.busy || bus.csr_wr || bus.done) seen = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL no_second_txn: got activity=1 want 0");
    end
    sb.push_back('{4'd0, 12'h0, 32'h0, 4'd2,
                   32'h0000_0011, 1'b1, 1'b0});
    run_op(3'd2, 12'h140, 32'hFFFF_FFFF, 5'd0, 5'd6, 1'b0, r);
    e = sb.pop_front();
    vectors++;
    if (r !== e) begin
      miscompares++;
      $display("FAIL reissue_read: got %h want %h", r, e);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.funct3 = '0;
    bus.csr_num = '0;
    bus.rs1_val = '0;
    bus.rs1_idx = '0;
    bus.rd_idx = '0;
    test_reset();
    test_rw();
    test_set();
    test_clear();
    test_counter();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
